// File: rtl/store_sequencer.sv
// Store sequencer: buffers store requests and issues byte-masked word writes to data memory.
// Latency: a request accepted into an empty buffer in cycle N drives MemWrite in cycle N+2.
// Backpressure: ReqReady drops when the buffer is full; memory writes are held stable until MemReady.
module store_sequencer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  input  logic [1:0]  ReqSize,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic [3:0]  MemByteMask,
  input  logic        MemReady,
  output logic        Busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  mask;
    logic        split;
  } wr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT} state_t;

  logic [31:0]      buf_addr [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [1:0]       buf_size [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, nxt_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;

  logic push, pop;
  wr_t  head_wr, head_b, next_wr;

  // Lane placement of one store; a halfword at offset 3 returns its first (upper-lane) half.
  function automatic wr_t decode(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wr_t w;
    w       = '0;
    w.addr  = {a[31:2], 2'b00};
    case (sz)
      2'b00: begin
        w.mask = 4'b0001 << a[1:0];
        w.dat  = {4{d[7:0]}};
      end
      2'b01: begin
        case (a[1:0])
          2'b00: begin w.mask = 4'b0011; w.dat = {2{d[15:0]}}; end
          2'b01: begin w.mask = 4'b0110; w.dat = {8'h00, d[15:0], 8'h00}; end
          2'b10: begin w.mask = 4'b1100; w.dat = {2{d[15:0]}}; end
          default: begin
            w.mask  = 4'b1000;
            w.dat   = {d[7:0], 24'h000000};
            w.split = 1'b1;
          end
        endcase
      end
      default: begin
        w.mask = 4'b1111;
        w.dat  = d;
      end
    endcase
    return w;
  endfunction

  // Second half of a boundary-crossing halfword: next word, lane 0, address wraps at 2^32.
  function automatic wr_t split_second(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w       = '0;
    w.addr  = {a[31:2], 2'b00} + 32'd4;
    w.dat   = {24'h000000, d[15:8]};
    w.mask  = 4'b0001;
    return w;
  endfunction

  assign nxt_ptr  = rd_ptr + PTR_ONE;
  assign ReqReady = (count != CNT_FULL);
  assign push     = ReqValid & ReqReady;
  assign Busy     = (count != '0) | (state != IDLE);

  // Decode the head entry and the entry behind it, and decide when the head retires.
  always_comb begin
    head_wr = decode(buf_addr[rd_ptr], buf_data[rd_ptr], buf_size[rd_ptr]);
    head_b  = split_second(buf_addr[rd_ptr], buf_data[rd_ptr]);
    next_wr = decode(buf_addr[nxt_ptr], buf_data[nxt_ptr], buf_size[nxt_ptr]);
    pop     = MemReady & (((state == ISSUE) & ~head_wr.split) | (state == SPLIT));
  end

  // Store buffer: circular FIFO with occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_addr[wr_ptr] <= ReqAddr;
        buf_data[wr_ptr] <= ReqData;
        buf_size[wr_ptr] <= ReqSize;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= nxt_ptr;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Write sequencer: loads registered memory outputs and holds them until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      MemWrite     <= 1'b0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      MemByteMask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            MemAddr      <= head_wr.addr;
            MemWriteData <= head_wr.dat;
            MemByteMask  <= head_wr.mask;
            MemWrite     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE, SPLIT: begin
          if (pop) begin
            // Only entries already buffered chain on; a same-cycle push waits for IDLE.
            if (count > CNT_ONE) begin
              MemAddr      <= next_wr.addr;
              MemWriteData <= next_wr.dat;
              MemByteMask  <= next_wr.mask;
              MemWrite     <= 1'b1;
              state        <= ISSUE;
            end else begin
              MemWrite <= 1'b0;
              state    <= IDLE;
            end
          end else if (state == ISSUE && MemReady) begin
            MemAddr      <= head_b.addr;
            MemWriteData <= head_b.dat;
            MemByteMask  <= head_b.mask;
            state        <= SPLIT;
          end
        end
        default: begin
          MemWrite <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: table of single stores plus multi-cycle sequences.
// Inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Memory backpressure is exercised with MemReady held low across several cycles.
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData;
  logic [1:0]  ReqSize;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [3:0]  MemByteMask;
  logic        MemReady;
  logic        Busy;

  int n_cmp = 0;
  int n_err = 0;

  store_sequencer #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqSize(ReqSize),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
    .MemByteMask(MemByteMask), .MemReady(MemReady), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        split;
    logic [31:0] a_addr;
    logic [31:0] a_data;
    logic [3:0]  a_mask;
    logic [31:0] b_addr;
    logic [31:0] b_data;
    logic [3:0]  b_mask;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_write(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    check({name, ".wr"},   {31'd0, MemWrite}, 32'd1);
    check({name, ".addr"}, MemAddr, a);
    check({name, ".data"}, MemWriteData, d);
    check({name, ".mask"}, {28'd0, MemByteMask}, {28'd0, m});
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ReqValid = v;
    ReqAddr  = a;
    ReqData  = d;
    ReqSize  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h00001002, 32'h000000AB, 2'b00, 1'b0, 32'h00001000, 32'hABABABAB, 4'b0100, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{32'h00002001, 32'h00001234, 2'b01, 1'b0, 32'h00002000, 32'h00123400, 4'b0110, 32'h0, 32'h0, 4'h0};
    vecs[2] = '{32'h000030FF, 32'h0000BEEF, 2'b01, 1'b1, 32'h000030FC, 32'hEF000000, 4'b1000, 32'h00003100, 32'h000000BE, 4'b0001};
    vecs[3] = '{32'hFFFFFFFF, 32'h0000CAFE, 2'b01, 1'b1, 32'hFFFFFFFC, 32'hFE000000, 4'b1000, 32'h00000000, 32'h000000CA, 4'b0001};
    vecs[4] = '{32'h00005003, 32'h123456C3, 2'b00, 1'b0, 32'h00005000, 32'hC3C3C3C3, 4'b1000, 32'h0, 32'h0, 4'h0};
    vecs[5] = '{32'h00004000, 32'hFFFF5678, 2'b01, 1'b0, 32'h00004000, 32'h56785678, 4'b0011, 32'h0, 32'h0, 4'h0};
    vecs[6] = '{32'h00004002, 32'h00009ABC, 2'b01, 1'b0, 32'h00004000, 32'h9ABC9ABC, 4'b1100, 32'h0, 32'h0, 4'h0};
    vecs[7] = '{32'h00006003, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00006000, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h0, 4'h0};
    vecs[8] = '{32'h00007001, 32'h01020304, 2'b11, 1'b0, 32'h00007000, 32'h01020304, 4'b1111, 32'h0, 32'h0, 4'h0};
    vecs[9] = '{32'h00008000, 32'h0000005A, 2'b00, 1'b0, 32'h00008000, 32'h5A5A5A5A, 4'b0001, 32'h0, 32'h0, 4'h0};

    reset    = 1'b1;
    MemReady = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst.MemWrite", {31'd0, MemWrite}, 32'd0);
    check("rst.MemAddr", MemAddr, 32'd0);
    check("rst.MemWriteData", MemWriteData, 32'd0);
    check("rst.MemByteMask", {28'd0, MemByteMask}, 32'd0);
    check("rst.Busy", {31'd0, Busy}, 32'd0);
    check("rst.ReqReady", {31'd0, ReqReady}, 32'd1);

    // Single stores into an empty buffer with memory always ready
    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      MemReady = 1'b1;
      set_req(1'b1, vecs[i].addr, vecs[i].data, vecs[i].size);
      check({nm, ".ready"}, {31'd0, ReqReady}, 32'd1);
      tick();
      set_req(1'b0, 32'h0, 32'h0, 2'b00);
      check({nm, ".n1_idle"}, {31'd0, MemWrite}, 32'd0);
      tick();
      check_write({nm, ".A"}, vecs[i].a_addr, vecs[i].a_data, vecs[i].a_mask);
      tick();
      if (vecs[i].split) begin
        check_write({nm, ".B"}, vecs[i].b_addr, vecs[i].b_data, vecs[i].b_mask);
        tick();
      end
      check({nm, ".done_wr"}, {31'd0, MemWrite}, 32'd0);
      check({nm, ".done_busy"}, {31'd0, Busy}, 32'd0);
    end

    // Backpressure: three word stores against a stalled memory
    MemReady = 1'b0;
    set_req(1'b1, 32'h00000100, 32'h11111111, 2'b10);
    check("bp.rdy0", {31'd0, ReqReady}, 32'd1);
    tick();
    set_req(1'b1, 32'h00000200, 32'h22222222, 2'b10);
    check("bp.rdy1", {31'd0, ReqReady}, 32'd1);
    tick();
    set_req(1'b1, 32'h00000300, 32'h33333333, 2'b10);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.full%0d", c), {31'd0, ReqReady}, 32'd0);
      check_write($sformatf("bp.hold%0d", c), 32'h00000100, 32'h11111111, 4'b1111);
      tick();
    end
    MemReady = 1'b1;
    check_write("bp.w0", 32'h00000100, 32'h11111111, 4'b1111);
    tick();
    check("bp.rdy_after_pop", {31'd0, ReqReady}, 32'd1);
    check_write("bp.w1", 32'h00000200, 32'h22222222, 4'b1111);
    tick();
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    check("bp.gap", {31'd0, MemWrite}, 32'd0);
    tick();
    check_write("bp.w2", 32'h00000300, 32'h33333333, 4'b1111);
    tick();
    check("bp.end_wr", {31'd0, MemWrite}, 32'd0);
    check("bp.end_busy", {31'd0, Busy}, 32'd0);

    // Reset while write B of a split is pending with another entry buffered
    MemReady = 1'b0;
    set_req(1'b1, 32'h000030FF, 32'h0000BEEF, 2'b01);
    tick();
    set_req(1'b1, 32'h00001002, 32'h000000AB, 2'b00);
    tick();
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    check_write("rs.A", 32'h000030FC, 32'hEF000000, 4'b1000);
    MemReady = 1'b1;
    tick();
    MemReady = 1'b0;
    check_write("rs.B", 32'h00003100, 32'h000000BE, 4'b0001);
    check("rs.busy_pre", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs.MemWrite", {31'd0, MemWrite}, 32'd0);
    check("rs.Busy", {31'd0, Busy}, 32'd0);
    check("rs.ReqReady", {31'd0, ReqReady}, 32'd1);
    check("rs.MemAddr", MemAddr, 32'd0);
    MemReady = 1'b1;
    begin
      int writes_seen;
      writes_seen = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (MemWrite) writes_seen++;
      end
      check("rs.no_writes", writes_seen, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
